// File: rtl/mbn_pipe_top.sv
// Pipelined radix-4 Booth multiplier with carry-save result and valid/ready flow control.
// Optional macro MBN_CPA_EN adds a registered prod = sum1 + carry1 output.
module mbn_pipe_top #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               tc,
  input  logic [WIDTH-1:0]   mx1,
  input  logic [WIDTH-1:0]   my1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] sum1,
  output logic [2*WIDTH-1:0] carry1,
  output logic [WIDTH-1:0]   mx2,
  output logic [WIDTH-1:0]   my2,
  output logic               tc2
`ifdef MBN_CPA_EN
  ,
  output logic [2*WIDTH-1:0] prod
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int EW = WIDTH + 2;
  localparam int ND = EW / 2;

  // Digit i of the tc-extended multiplier times the tc-extended multiplicand, weighted 4^i.
  // Rows are carried at full product width, so sign extension is implicit modulo 2^PW.
  function automatic logic [PW-1:0] booth_pp(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             t,
                                             input int               i);
    logic [EW:0]   yp;
    logic [PW-1:0] xs;
    logic [2:0]    trip;
    logic [PW-1:0] pp;
    yp   = {{2{t & y[WIDTH-1]}}, y, 1'b0};
    xs   = t ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    trip = yp[2*i +: 3];
    case (trip)
      3'b001, 3'b010: pp = xs;
      3'b011:         pp = xs << 1;
      3'b100:         pp = -(xs << 1);
      3'b101, 3'b110: pp = -xs;
      default:        pp = '0;
    endcase
    return pp << (2 * i);
  endfunction

  logic             v_q [0:PIPE];
  logic [WIDTH-1:0] x_q [0:PIPE];
  logic [WIDTH-1:0] y_q [0:PIPE];
  logic             t_q [0:PIPE];
  logic [PW-1:0]    s_q [0:PIPE];
  logic [PW-1:0]    c_q [0:PIPE];
  logic [PW-1:0]    s_nxt [1:PIPE];
  logic [PW-1:0]    c_nxt [1:PIPE];
  logic             stall;

  assign stall    = v_q[PIPE] && !out_ready;
  assign in_ready = !stall;

  // Stage j folds recode rows [(j-1)*ND/PIPE, j*ND/PIPE) into the running carry-save pair.
  always_comb begin
    logic [PW-1:0] acc_s;
    logic [PW-1:0] acc_c;
    logic [PW-1:0] pp;
    logic [PW-1:0] maj;
    acc_s = '0;
    acc_c = '0;
    pp    = '0;
    maj   = '0;
    for (int j = 1; j <= PIPE; j++) begin
      acc_s = s_q[j-1];
      acc_c = c_q[j-1];
      for (int r = 0; r < ND; r++) begin
        if (r >= ((j - 1) * ND) / PIPE && r < (j * ND) / PIPE) begin
          pp    = booth_pp(x_q[j-1], y_q[j-1], t_q[j-1], r);
          maj   = (acc_s & acc_c) | (acc_s & pp) | (acc_c & pp);
          acc_s = acc_s ^ acc_c ^ pp;
          acc_c = maj << 1;
        end
      end
      s_nxt[j] = acc_s;
      c_nxt[j] = acc_c;
    end
  end

  // Stage 0 accumulators stay zero: they seed the first reduction stage.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int k = 0; k <= PIPE; k++) begin
        v_q[k] <= 1'b0;
        x_q[k] <= '0;
        y_q[k] <= '0;
        t_q[k] <= 1'b0;
        s_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q[0] <= in_valid;
      x_q[0] <= mx1;
      y_q[0] <= my1;
      t_q[0] <= tc;
      s_q[0] <= '0;
      c_q[0] <= '0;
      for (int k = 1; k <= PIPE; k++) begin
        v_q[k] <= v_q[k-1];
        x_q[k] <= x_q[k-1];
        y_q[k] <= y_q[k-1];
        t_q[k] <= t_q[k-1];
        s_q[k] <= s_nxt[k];
        c_q[k] <= c_nxt[k];
      end
    end
  end

`ifdef MBN_CPA_EN
  logic [PW-1:0] prod_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      prod_q <= '0;
    end else if (!stall) begin
      prod_q <= s_nxt[PIPE] + c_nxt[PIPE];
    end
  end

  assign prod = prod_q;
`endif

  assign out_valid = v_q[PIPE];
  assign sum1      = s_q[PIPE];
  assign carry1    = c_q[PIPE];
  assign mx2       = x_q[PIPE];
  assign my2       = y_q[PIPE];
  assign tc2       = t_q[PIPE];

endmodule

// File: tb/tb_mbn_pipe_top.sv
// Bench for mbn_pipe_top: directed literal cases plus randomized sweeps over several
// WIDTH/PIPE configurations, all checked against a queue-based arithmetic reference.
`timescale 1ns/1ps
module tb_mbn_pipe_top;
  localparam int W   = 8;
  localparam int P   = 2;
  localparam int LAT = P + 1;

  typedef struct {
    bit          t;
    logic [31:0] x;
    logic [31:0] y;
  } txn_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  bit   mon_on = 1'b0;
  bit   sweep_on = 1'b0;
  bit   end_chk = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input int w, input bit t,
                                           input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    logic [63:0] m;
    sx = longint'(x);
    sy = longint'(y);
    if (t && x[w-1]) sx = sx - (longint'(1) << w);
    if (t && y[w-1]) sy = sy - (longint'(1) << w);
    p = sx * sy;
    m = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & m;
  endfunction

  function automatic logic [63:0] cs_sum(input int w, input logic [63:0] s, input logic [63:0] c);
    return (s + c) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic [31:0] rnd_op(input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3:       return m >> 1;
      default: return $urandom() & m;
    endcase
  endfunction

  // ---------------- main DUT (WIDTH=8, PIPE=2) ----------------
  logic           iv = 1'b0, tc = 1'b0, orr = 1'b1;
  logic [W-1:0]   a = '0, b = '0;
  logic           ir, ov, t2;
  logic [2*W-1:0] s1, c1;
  logic [W-1:0]   x2, y2;
`ifdef MBN_CPA_EN
  logic [2*W-1:0] pr;
`endif

  mbn_pipe_top #(.WIDTH(W), .PIPE(P)) u_dut (
    .CLK(clk), .RST(rst_b), .in_valid(iv), .in_ready(ir), .tc(tc), .mx1(a), .my1(b),
    .out_valid(ov), .out_ready(orr), .sum1(s1), .carry1(c1), .mx2(x2), .my2(y2), .tc2(t2)
`ifdef MBN_CPA_EN
    , .prod(pr)
`endif
  );

  txn_t mq[$];
  int accepted = 0;
  int delivered = 0;
  bit h_chk = 1'b0;
  logic [2*W-1:0] h_s, h_c;
  logic [W-1:0]   h_x, h_y;
  logic           h_t;

  // Handshakes seen here take effect at the next rising edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (h_chk) begin
        chk("hold_sum1", 64'(s1), 64'(h_s));
        chk("hold_carry1", 64'(c1), 64'(h_c));
        chk("hold_mx2", 64'(x2), 64'(h_x));
        chk("hold_my2", 64'(y2), 64'(h_y));
        chk("hold_tc2", 64'(t2), 64'(h_t));
      end
      h_chk = ov && !orr && rst_b;
      h_s = s1; h_c = c1; h_x = x2; h_y = y2; h_t = t2;
      if (mq.size() == 0) begin
        chk("no_stale_out_valid", 64'(ov), 64'd0);
      end else if (ov) begin
        chk("model_product", cs_sum(W, 64'(s1), 64'(c1)), ref_prod(W, mq[0].t, mq[0].x, mq[0].y));
        chk("model_mx2", 64'(x2), 64'(mq[0].x));
        chk("model_my2", 64'(y2), 64'(mq[0].y));
        chk("model_tc2", 64'(t2), 64'(mq[0].t));
`ifdef MBN_CPA_EN
        chk("model_prod_port", 64'(pr), ref_prod(W, mq[0].t, mq[0].x, mq[0].y));
`endif
        if (orr) begin
          void'(mq.pop_front());
          delivered++;
        end
      end
      if (iv && ir && rst_b) begin
        mq.push_back('{t: tc, x: 32'(a), y: 32'(b)});
        accepted++;
      end
      if (!rst_b) mq.delete();
    end
  end

  // ---------------- sweep DUTs ----------------
  localparam int NS = 4;
  localparam int SW [NS] = '{16, 8, 16, 8};
  localparam int SP [NS] = '{3, 1, 1, 3};

  for (genvar g = 0; g < NS; g++) begin : g_sweep
    localparam int GW = SW[g];
    localparam int GP = SP[g];
    logic            g_iv = 1'b0, g_tc = 1'b0, g_orr = 1'b1;
    logic [GW-1:0]   g_a = '0, g_b = '0;
    logic            g_ir, g_ov, g_t2;
    logic [2*GW-1:0] g_s, g_c;
    logic [GW-1:0]   g_x2, g_y2;
    logic [31:0]     g_r;
    bit              g_done = 1'b0;
`ifdef MBN_CPA_EN
    logic [2*GW-1:0] g_p;
`endif
    txn_t q[$];

    mbn_pipe_top #(.WIDTH(GW), .PIPE(GP)) u_dut (
      .CLK(clk), .RST(rst_b), .in_valid(g_iv), .in_ready(g_ir), .tc(g_tc), .mx1(g_a),
      .my1(g_b), .out_valid(g_ov), .out_ready(g_orr), .sum1(g_s), .carry1(g_c), .mx2(g_x2),
      .my2(g_y2), .tc2(g_t2)
`ifdef MBN_CPA_EN
      , .prod(g_p)
`endif
    );

    always @(posedge clk) begin
      #1;
      g_iv  = sweep_on && ($urandom_range(0, 3) != 0);
      g_orr = !sweep_on || ($urandom_range(0, 2) != 0);
      g_tc  = 1'($urandom_range(0, 1));
      g_r   = rnd_op(GW);
      g_a   = g_r[GW-1:0];
      g_r   = rnd_op(GW);
      g_b   = g_r[GW-1:0];
    end

    always @(negedge clk) begin
      if (mon_on) begin
        if (q.size() == 0) begin
          chk($sformatf("sweep%0d_no_stale", g), 64'(g_ov), 64'd0);
        end else if (g_ov) begin
          chk($sformatf("sweep%0d_product", g), cs_sum(GW, 64'(g_s), 64'(g_c)),
              ref_prod(GW, q[0].t, q[0].x, q[0].y));
          chk($sformatf("sweep%0d_mx2", g), 64'(g_x2), 64'(q[0].x));
          chk($sformatf("sweep%0d_my2", g), 64'(g_y2), 64'(q[0].y));
          chk($sformatf("sweep%0d_tc2", g), 64'(g_t2), 64'(q[0].t));
`ifdef MBN_CPA_EN
          chk($sformatf("sweep%0d_prod", g), 64'(g_p), ref_prod(GW, q[0].t, q[0].x, q[0].y));
`endif
          if (g_orr) void'(q.pop_front());
        end
        if (g_iv && g_ir && rst_b) q.push_back('{t: g_tc, x: 32'(g_a), y: 32'(g_b)});
        if (!rst_b) q.delete();
        if (end_chk && !g_done) begin
          chk($sformatf("sweep%0d_drained", g), 64'(q.size()), 64'd0);
          g_done = 1'b1;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(ov), 64'd0);
    chk({tag, "_sum1"}, 64'(s1), 64'd0);
    chk({tag, "_carry1"}, 64'(c1), 64'd0);
    chk({tag, "_mx2"}, 64'(x2), 64'd0);
    chk({tag, "_my2"}, 64'(y2), 64'd0);
    chk({tag, "_tc2"}, 64'(t2), 64'd0);
    chk({tag, "_in_ready"}, 64'(ir), 64'd1);
`ifdef MBN_CPA_EN
    chk({tag, "_prod"}, 64'(pr), 64'd0);
`endif
  endtask

  task automatic run_one(input bit t, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [15:0] exp);
    int n;
    n = 0;
    tc = t; a = x; b = y; iv = 1'b1;
    do begin
      tick();
      iv = 1'b0;
      n++;
    end while (!ov && n < 20);
    chk("lit_latency", 64'(n), 64'(LAT));
    chk("lit_product", cs_sum(W, 64'(s1), 64'(c1)), 64'(exp));
    chk("lit_mx2", 64'(x2), 64'(x));
    chk("lit_my2", 64'(y2), 64'(y));
    tick();
  endtask

  initial begin
    int n, acc0, del0;
    logic [2*W-1:0] snap_s, snap_c;
    logic [W-1:0]   snap_x, snap_y;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    mon_on = 1'b1;
    rst_b  = 1'b1;

    run_one(1'b1, 8'h80, 8'h80, 16'h4000);
    run_one(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_one(1'b1, 8'hFF, 8'hFF, 16'h0001);

    // back-to-back signed pairs
    tc = 1'b1; iv = 1'b1;
    a = 8'hFF; b = 8'h01; tick();
    a = 8'h7F; b = 8'h80; tick();
    a = 8'h00; b = 8'h5A; tick();
    iv = 1'b0;
    n = 0;
    while (!ov && n < 20) begin tick(); n++; end
    chk("b2b_valid0", 64'(ov), 64'd1);
    chk("b2b_result0", cs_sum(W, 64'(s1), 64'(c1)), 64'h0000_FFFF);
    tick();
    chk("b2b_valid1", 64'(ov), 64'd1);
    chk("b2b_result1", cs_sum(W, 64'(s1), 64'(c1)), 64'h0000_C080);
    tick();
    chk("b2b_valid2", 64'(ov), 64'd1);
    chk("b2b_result2", cs_sum(W, 64'(s1), 64'(c1)), 64'h0000_0000);
    tick();

    // fill under backpressure, hold 5 cycles, then drain
    orr = 1'b0; iv = 1'b1;
    acc0 = accepted;
    for (int i = 0; i < 6; i++) begin
      tc = 1'($urandom_range(0, 1));
      a = 8'($urandom()); b = 8'($urandom());
      tick();
    end
    chk("fill_accepted", 64'(accepted - acc0), 64'(LAT));
    snap_s = s1; snap_c = c1; snap_x = x2; snap_y = y2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", 64'(ir), 64'd0);
      chk("stall_out_valid", 64'(ov), 64'd1);
      chk("stall_sum_stable", 64'({s1, c1}), 64'({snap_s, snap_c}));
      chk("stall_ops_stable", 64'({x2, y2}), 64'({snap_x, snap_y}));
    end
    orr = 1'b1; iv = 1'b0;
    del0 = delivered;
    n = 0;
    while (mq.size() != 0 && n < 20) begin tick(); n++; end
    chk("drain_count", 64'(delivered - del0), 64'(LAT));
    tick();
    chk("drain_idle", 64'(ov), 64'd0);

    // reset with transactions in flight
    iv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tc = 1'($urandom_range(0, 1));
      a = 8'($urandom()); b = 8'($urandom());
      tick();
    end
    rst_b = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_b = 1'b1; iv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_reset_no_valid", 64'(ov), 64'd0);
    end

    // randomized traffic on all instances
    sweep_on = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      tc  = 1'($urandom_range(0, 1));
      a   = 8'(rnd_op(W));
      b   = 8'(rnd_op(W));
      tick();
    end
    sweep_on = 1'b0;
    iv = 1'b0; orr = 1'b1;
    repeat (20) tick();
    chk("final_drained", 64'(mq.size()), 64'd0);
    end_chk = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
